// File: rtl/cc_carmove_controller.sv
// Car lateral-move controller: button-held auto-repeat moves on game ticks,
// edge blocking via the external side comparator, and a timed crash freeze.
module cc_carmove_controller #(
   parameter int unsigned          DATAWIDTH   = 8,
   parameter int unsigned          MOVE_TICKS  = 4,
   parameter int unsigned          CRASH_TICKS = 16,
   parameter logic [DATAWIDTH-1:0] START_POS   = 8'b00100000
) (
   input  logic                 CC_CARMOVE_CONTROLLER_CLOCK_50,
   input  logic                 CC_CARMOVE_CONTROLLER_RESET_InLow,
   input  logic                 CC_CARMOVE_CONTROLLER_left_InLow,
   input  logic                 CC_CARMOVE_CONTROLLER_right_InLow,
   input  logic                 CC_CARMOVE_CONTROLLER_tick_InHigh,
   input  logic                 CC_CARMOVE_CONTROLLER_crash_InHigh,
   input  logic                 CC_CARMOVE_CONTROLLER_side_InLow,
   output logic [DATAWIDTH-1:0] CC_CARMOVE_CONTROLLER_data_OutBUS,
   output logic                 CC_CARMOVE_CONTROLLER_moving_OutHigh,
   output logic                 CC_CARMOVE_CONTROLLER_blocked_OutHigh,
   output logic                 CC_CARMOVE_CONTROLLER_crashed_OutHigh
);

   localparam int unsigned MAX_TICKS = (CRASH_TICKS > MOVE_TICKS) ? CRASH_TICKS : MOVE_TICKS;
   localparam int unsigned CW        = ($clog2(MAX_TICKS) < 4) ? 4 : $clog2(MAX_TICKS);

   localparam logic [DATAWIDTH-1:0] POS_80 = DATAWIDTH'(8'h80);
   localparam logic [DATAWIDTH-1:0] POS_40 = DATAWIDTH'(8'h40);
   localparam logic [DATAWIDTH-1:0] POS_20 = DATAWIDTH'(8'h20);
   localparam logic [DATAWIDTH-1:0] POS_10 = DATAWIDTH'(8'h10);

   typedef enum logic [1:0] {IDLE, ARMED, MOVE, CRASH} state_t;
   typedef enum logic {LEFT, RIGHT} dir_t;

   state_t        state;
   dir_t          dir;
   logic [CW-1:0] cnt;

   logic only_left, only_right, held, opposite, valid_pos;

   always_comb begin
      only_left  = !CC_CARMOVE_CONTROLLER_left_InLow && CC_CARMOVE_CONTROLLER_right_InLow;
      only_right = !CC_CARMOVE_CONTROLLER_right_InLow && CC_CARMOVE_CONTROLLER_left_InLow;
      held       = (dir == LEFT) ? only_left : only_right;
      opposite   = (dir == LEFT) ? only_right : only_left;
      valid_pos  = (CC_CARMOVE_CONTROLLER_data_OutBUS == POS_80) ||
                   (CC_CARMOVE_CONTROLLER_data_OutBUS == POS_40) ||
                   (CC_CARMOVE_CONTROLLER_data_OutBUS == POS_20) ||
                   (CC_CARMOVE_CONTROLLER_data_OutBUS == POS_10);
   end

   always_ff @(posedge CC_CARMOVE_CONTROLLER_CLOCK_50 or negedge CC_CARMOVE_CONTROLLER_RESET_InLow) begin
      if (!CC_CARMOVE_CONTROLLER_RESET_InLow) begin
         state                                 <= IDLE;
         dir                                   <= LEFT;
         cnt                                   <= '0;
         CC_CARMOVE_CONTROLLER_data_OutBUS     <= START_POS;
         CC_CARMOVE_CONTROLLER_moving_OutHigh  <= 1'b0;
         CC_CARMOVE_CONTROLLER_blocked_OutHigh <= 1'b0;
         CC_CARMOVE_CONTROLLER_crashed_OutHigh <= 1'b0;
      end else begin
         CC_CARMOVE_CONTROLLER_moving_OutHigh  <= 1'b0;
         CC_CARMOVE_CONTROLLER_blocked_OutHigh <= 1'b0;
         // Crash overrides every state, including a move about to execute.
         if (CC_CARMOVE_CONTROLLER_crash_InHigh) begin
            state                                 <= CRASH;
            cnt                                   <= '0;
            CC_CARMOVE_CONTROLLER_crashed_OutHigh <= 1'b1;
         end else begin
            case (state)
               IDLE: begin
                  cnt <= '0;
                  if (only_left) begin
                     state <= ARMED;
                     dir   <= LEFT;
                  end else if (only_right) begin
                     state <= ARMED;
                     dir   <= RIGHT;
                  end
               end
               ARMED: begin
                  if (opposite) begin
                     dir <= (dir == LEFT) ? RIGHT : LEFT;
                     cnt <= '0;
                  end else if (!held) begin
                     state <= IDLE;
                     cnt   <= '0;
                  end else if (CC_CARMOVE_CONTROLLER_tick_InHigh) begin
                     if (cnt == CW'(MOVE_TICKS - 1)) begin
                        state <= MOVE;
                        cnt   <= '0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               MOVE: begin
                  cnt   <= '0;
                  state <= held ? ARMED : IDLE;
                  if (!valid_pos) begin
                     CC_CARMOVE_CONTROLLER_data_OutBUS <= START_POS;
                  end else if (dir == LEFT) begin
                     if (!CC_CARMOVE_CONTROLLER_side_InLow && CC_CARMOVE_CONTROLLER_data_OutBUS == POS_80) begin
                        CC_CARMOVE_CONTROLLER_blocked_OutHigh <= 1'b1;
                     end else begin
                        CC_CARMOVE_CONTROLLER_data_OutBUS    <= CC_CARMOVE_CONTROLLER_data_OutBUS << 1;
                        CC_CARMOVE_CONTROLLER_moving_OutHigh <= 1'b1;
                     end
                  end else begin
                     if (!CC_CARMOVE_CONTROLLER_side_InLow && CC_CARMOVE_CONTROLLER_data_OutBUS == POS_10) begin
                        CC_CARMOVE_CONTROLLER_blocked_OutHigh <= 1'b1;
                     end else begin
                        CC_CARMOVE_CONTROLLER_data_OutBUS    <= CC_CARMOVE_CONTROLLER_data_OutBUS >> 1;
                        CC_CARMOVE_CONTROLLER_moving_OutHigh <= 1'b1;
                     end
                  end
               end
               CRASH: begin
                  CC_CARMOVE_CONTROLLER_crashed_OutHigh <= 1'b1;
                  if (CC_CARMOVE_CONTROLLER_tick_InHigh) begin
                     if (cnt == CW'(CRASH_TICKS - 1)) begin
                        state                                 <= IDLE;
                        cnt                                   <= '0;
                        CC_CARMOVE_CONTROLLER_data_OutBUS     <= START_POS;
                        CC_CARMOVE_CONTROLLER_crashed_OutHigh <= 1'b0;
                     end else begin
                        cnt <= cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cc_carmove_controller.sv
// Directed bench for cc_carmove_controller; the side comparator is modelled
// here from the position bus as it would be on the board.
module tb_cc_carmove_controller;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       left_n = 1'b1;
   logic       right_n = 1'b1;
   logic       tick = 1'b0;
   logic       crash = 1'b0;
   logic       side_n;
   logic [7:0] data;
   logic       moving, blocked, crashed;

   int n_checks = 0;
   int n_fails  = 0;
   int mv_cnt   = 0;
   int bl_cnt   = 0;
   int both_cnt = 0;

   always #5 clk = ~clk;

   assign side_n = !(data == 8'h80 || data == 8'h10);

   cc_carmove_controller #(
      .DATAWIDTH(8),
      .MOVE_TICKS(4),
      .CRASH_TICKS(16),
      .START_POS(8'b00100000)
   ) dut (
      .CC_CARMOVE_CONTROLLER_CLOCK_50       (clk),
      .CC_CARMOVE_CONTROLLER_RESET_InLow    (rst_n),
      .CC_CARMOVE_CONTROLLER_left_InLow     (left_n),
      .CC_CARMOVE_CONTROLLER_right_InLow    (right_n),
      .CC_CARMOVE_CONTROLLER_tick_InHigh    (tick),
      .CC_CARMOVE_CONTROLLER_crash_InHigh   (crash),
      .CC_CARMOVE_CONTROLLER_side_InLow     (side_n),
      .CC_CARMOVE_CONTROLLER_data_OutBUS    (data),
      .CC_CARMOVE_CONTROLLER_moving_OutHigh (moving),
      .CC_CARMOVE_CONTROLLER_blocked_OutHigh(blocked),
      .CC_CARMOVE_CONTROLLER_crashed_OutHigh(crashed)
   );

   // Pulses are one cycle wide, so sampling once per cycle counts each once.
   always @(negedge clk) begin
      if (rst_n) begin
         if (moving)            mv_cnt++;
         if (blocked)           bl_cnt++;
         if (moving && blocked) both_cnt++;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic do_ticks(input int n, input bit crash_last);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tick = 1'b1;
         if (crash_last && i == n - 1) crash = 1'b1;
         @(negedge clk);
         tick  = 1'b0;
         crash = 1'b0;
         @(negedge clk);
         @(negedge clk);
      end
   endtask

   task automatic crash_pulse();
      @(negedge clk);
      crash = 1'b1;
      @(negedge clk);
      crash = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_data",    {24'd0, data}, 32'h20);
      check("rst_moving",  {31'd0, moving}, 32'd0);
      check("rst_blocked", {31'd0, blocked}, 32'd0);
      check("rst_crashed", {31'd0, crashed}, 32'd0);
      rst_n = 1'b1;

      // Left auto-repeat up to the left edge, then refused.
      left_n = 1'b0;
      repeat (2) @(negedge clk);
      do_ticks(3, 1'b0);
      check("left_3ticks_data", {24'd0, data}, 32'h20);
      check("left_3ticks_mv",   mv_cnt, 0);
      do_ticks(1, 1'b0);
      check("left_1_data", {24'd0, data}, 32'h40);
      check("left_1_mv",   mv_cnt, 1);
      do_ticks(4, 1'b0);
      check("left_2_data", {24'd0, data}, 32'h80);
      check("left_2_mv",   mv_cnt, 2);
      do_ticks(4, 1'b0);
      check("left_edge_bl",   bl_cnt, 1);
      check("left_edge_data", {24'd0, data}, 32'h80);
      check("left_edge_mv",   mv_cnt, 2);

      // Asynchronous reset in the middle of a crash freeze.
      crash_pulse();
      check("crash80_crashed", {31'd0, crashed}, 32'd1);
      do_ticks(3, 1'b0);
      check("crash80_data", {24'd0, data}, 32'h80);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_data",    {24'd0, data}, 32'h20);
      check("async_rst_crashed", {31'd0, crashed}, 32'd0);
      left_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;

      // Right auto-repeat to the right edge, then refused; both buttons idle.
      right_n = 1'b0;
      repeat (2) @(negedge clk);
      do_ticks(4, 1'b0);
      check("right_1_data", {24'd0, data}, 32'h10);
      check("right_1_mv",   mv_cnt, 3);
      do_ticks(4, 1'b0);
      check("right_edge_bl",   bl_cnt, 2);
      check("right_edge_data", {24'd0, data}, 32'h10);
      left_n = 1'b0;
      repeat (2) @(negedge clk);
      do_ticks(8, 1'b0);
      check("both_low_mv",   mv_cnt, 3);
      check("both_low_bl",   bl_cnt, 2);
      check("both_low_data", {24'd0, data}, 32'h10);
      left_n  = 1'b1;
      right_n = 1'b1;
      repeat (2) @(negedge clk);

      // Crash coincident with the move-triggering tick, then full freeze.
      left_n = 1'b0;
      repeat (2) @(negedge clk);
      do_ticks(4, 1'b1);
      left_n = 1'b1;
      check("crash_tick_data",    {24'd0, data}, 32'h10);
      check("crash_tick_mv",      mv_cnt, 3);
      check("crash_tick_crashed", {31'd0, crashed}, 32'd1);
      do_ticks(15, 1'b0);
      check("freeze15_crashed", {31'd0, crashed}, 32'd1);
      check("freeze15_data",    {24'd0, data}, 32'h10);
      do_ticks(1, 1'b0);
      check("recover_data",    {24'd0, data}, 32'h20);
      check("recover_crashed", {31'd0, crashed}, 32'd0);

      // Second crash mid-freeze restarts the full count.
      crash_pulse();
      do_ticks(10, 1'b0);
      crash_pulse();
      do_ticks(15, 1'b0);
      check("restart15_crashed", {31'd0, crashed}, 32'd1);
      do_ticks(1, 1'b0);
      check("restart16_crashed", {31'd0, crashed}, 32'd0);
      check("restart16_data",    {24'd0, data}, 32'h20);

      // Switching to the opposite button relatches and clears the count.
      left_n = 1'b0;
      repeat (2) @(negedge clk);
      do_ticks(2, 1'b0);
      left_n  = 1'b1;
      right_n = 1'b0;
      repeat (2) @(negedge clk);
      do_ticks(3, 1'b0);
      check("relatch_3_data", {24'd0, data}, 32'h20);
      check("relatch_3_mv",   mv_cnt, 4 - 1);
      do_ticks(1, 1'b0);
      check("relatch_4_data", {24'd0, data}, 32'h10);
      check("relatch_4_mv",   mv_cnt, 4);
      right_n = 1'b1;
      repeat (2) @(negedge clk);

      check("moving_and_blocked_together", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/cc_carmove_controller.md
CC_CARMOVE_CONTROLLER -- requirements
Module: CC_CARMOVE_CONTROLLER

Interface
REQ-001 The block SHALL have parameter DATAWIDTH, default 8, meaning position bus width.
REQ-002 The block SHALL have parameter MOVE_TICKS, default 4, meaning ticks between successive lateral moves while a button is held.
REQ-003 The block SHALL have parameter CRASH_TICKS, default 16, meaning ticks the car stays frozen after a crash.
REQ-004 The block SHALL have parameter START_POS, default 8'b00100000, meaning the car position after reset or crash recovery.
REQ-005 The block SHALL have port CC_CARMOVE_CONTROLLER_CLOCK_50, input, 1 bit, meaning the single system clock; all state changes on its rising edge.
REQ-006 The block SHALL have port CC_CARMOVE_CONTROLLER_RESET_InLow, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 The block SHALL have port CC_CARMOVE_CONTROLLER_left_InLow, input, 1 bit, meaning debounced left button, active-low level.
REQ-008 The block SHALL have port CC_CARMOVE_CONTROLLER_right_InLow, input, 1 bit, meaning debounced right button, active-low level.
REQ-009 The block SHALL have port CC_CARMOVE_CONTROLLER_tick_InHigh, input, 1 bit, meaning one-cycle game-rate pulse.
REQ-010 The block SHALL have port CC_CARMOVE_CONTROLLER_crash_InHigh, input, 1 bit, meaning one-cycle collision pulse.
REQ-011 The block SHALL have port CC_CARMOVE_CONTROLLER_side_InLow, input, 1 bit, meaning side-comparator result for the current position bus: 0 = car at a road edge (8'b10000000 or 8'b00010000).
REQ-012 The block SHALL have port CC_CARMOVE_CONTROLLER_data_OutBUS, output, DATAWIDTH bits, meaning one-hot car position; bit 7 = leftmost lane; feeds the side comparator.
REQ-013 The block SHALL have port CC_CARMOVE_CONTROLLER_moving_OutHigh, output, 1 bit, meaning one-cycle pulse on each successful move.
REQ-014 The block SHALL have port CC_CARMOVE_CONTROLLER_blocked_OutHigh, output, 1 bit, meaning one-cycle pulse when a move is refused at an edge.
REQ-015 The block SHALL have port CC_CARMOVE_CONTROLLER_crashed_OutHigh, output, 1 bit, meaning level, high for the whole crash freeze.

Function
REQ-016 The FSM SHALL have states IDLE, ARMED, MOVE, CRASH; 4-bit-or-wider tick counter shared by ARMED and CRASH.
REQ-017 The FSM in IDLE SHALL go to ARMED with direction latched (LEFT or RIGHT) when exactly one button is low; both low or none low stays in IDLE.
REQ-018 The FSM in ARMED SHALL increment the counter on each tick; on the tick where counter == MOVE_TICKS-1 it SHALL go to MOVE.
REQ-019 The FSM in ARMED SHALL return to IDLE with counter cleared when the latched button is released or both buttons are low; a press of the opposite button alone SHALL relatch direction and clear the counter.
REQ-020 The FSM in MOVE, lasting exactly one cycle, SHALL shift position left (toward bit 7) for LEFT unless side_InLow=0 and position=8'b10000000, and SHALL shift position right for RIGHT unless side_InLow=0 and position=8'b00010000.
REQ-021 A successful move SHALL assert moving_OutHigh for that cycle; a refused move SHALL leave position unchanged and assert blocked_OutHigh for that cycle; the two SHALL never be high together.
REQ-022 If the position is not one of 8'h80, 8'h40, 8'h20 or 8'h10 in MOVE, the block SHALL load START_POS and assert neither pulse.
REQ-023 From MOVE, the FSM SHALL go to ARMED with counter 0 if the latched button is still the only one low, else to IDLE; a tick arriving in the MOVE cycle SHALL not be counted.
REQ-024 crash_InHigh SHALL move the FSM from any state to CRASH with counter cleared; crash SHALL take priority over tick and buttons in the same cycle.
REQ-025 In CRASH, crashed_OutHigh SHALL be 1, buttons SHALL be ignored, position SHALL be held, and the counter SHALL increment on each tick.
REQ-026 In CRASH, on the tick where counter == CRASH_TICKS-1, the block SHALL load START_POS and go to IDLE, with crashed_OutHigh low from the next cycle.
REQ-027 A new crash pulse during CRASH SHALL clear the counter and restart the freeze.
REQ-028 All outputs SHALL be registered.

Reset
REQ-029 While RESET_InLow=0, the block SHALL hold state IDLE, counter 0, data_OutBUS=START_POS (8'h20), and moving, blocked and crashed outputs at 0, independent of the clock.
REQ-030 Reset asserted mid-move or mid-crash SHALL abort immediately with no pulse emitted; operation SHALL resume on the first clock edge after deassertion.

Verification
REQ-031 Reset, then hold left low, 4 ticks -> moving pulse once, data_OutBUS 8'h20->8'h40; 4 more ticks -> 8'h80.
REQ-032 At 8'h80 with side_InLow=0, hold left, 4 ticks -> blocked pulse, bus stays 8'h80, moving=0.
REQ-033 Hold right from 8'h20, 4 ticks -> 8'h10; 4 more ticks -> blocked pulse; both buttons low -> IDLE, no pulses for 8 ticks.
REQ-034 Crash pulse coincident with the 4th tick while ARMED -> no move, crashed=1; 15 ticks -> still frozen; 16th tick -> bus 8'h20, crashed=0 next cycle.
REQ-035 Crash again after 10 ticks of freeze -> 16 further ticks required before recovery.
REQ-036 Reset pulse mid-CRASH at position 8'h80 -> bus 8'h20 asynchronously, crashed=0.
